// File: rtl/alu_acc_pkg.sv
// Shared definitions for the accumulator ALU: opcodes, FSM states and
// bit positions in the status-flag register.
package alu_acc_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_ORN  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_ANDN = 4'b0101;
  localparam logic [3:0] OP_NOTA = 4'b0110;
  localparam logic [3:0] OP_NOTB = 4'b0111;
  localparam logic [3:0] OP_LOAD = 4'b1000;
  localparam logic [3:0] OP_SHL  = 4'b1001;
  localparam logic [3:0] OP_SHR  = 4'b1010;
  localparam logic [3:0] OP_MUL  = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_MUL   = 2'd2
  } state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_word.sv
// Combinational WIDTH-bit ALU for the single-cycle opcodes (ADD..LOAD).
// Opcodes outside that range produce zero; the top level never uses them.
module alu_word
  import alu_acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH:0]   sum;

  // SUB reuses the adder as A + ~B + 1, so carry=1 means no borrow
  assign is_sub = (op == OP_SUB);
  assign b_eff  = is_sub ? ~b : b;
  assign c_eff  = is_sub ? 1'b1 : cin;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        result   = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_OR:   result = a | b;
      OP_ORN:  result = a | ~b;
      OP_AND:  result = a & b;
      OP_ANDN: result = a & ~b;
      OP_NOTA: result = ~a;
      OP_NOTB: result = ~b;
      OP_LOAD: result = b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_accumulator.sv
// Registered accumulator ALU with status flags, plus multi-cycle shift and
// shift-add multiply sequenced by a start/busy/done handshake.
module alu_accumulator
  import alu_acc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             in_clk,
  input  logic             in_reset,
  input  logic             in_start,
  input  logic [3:0]       in_control,
  input  logic [WIDTH-1:0] in_operand,
  input  logic             in_carry,
  output logic             out_busy,
  output logic             out_done,
  output logic [WIDTH-1:0] out_acc,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_negative,
  output logic             out_overflow
);

  localparam int KW = $clog2(WIDTH);
  localparam int CW = KW + 1;

  state_t             state, state_nx;
  logic [3:0]         op_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   sh_q, mplier_q;
  logic [2*WIDTH-1:0] mcand_q, prod_q;
  logic [3:0]         flags_q;
  logic               done_q;

  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   sh_nx;
  logic               sh_out;
  logic [2*WIDTH-1:0] prod_nx;

  logic               wr, done_nx, ld_shift, ld_mul, step;
  logic [WIDTH-1:0]   wr_res;
  logic               wr_c, wr_v;

  alu_word #(.WIDTH(WIDTH)) u_alu (
    .a        (out_acc),
    .b        (in_operand),
    .cin      (in_carry),
    .op       (in_control),
    .result   (alu_res),
    .carry    (alu_c),
    .overflow (alu_v)
  );

  assign k       = in_operand[KW-1:0];
  assign sh_nx   = (op_q == OP_SHL) ? {sh_q[WIDTH-2:0], 1'b0} : {1'b0, sh_q[WIDTH-1:1]};
  assign sh_out  = (op_q == OP_SHL) ? sh_q[WIDTH-1] : sh_q[0];
  assign prod_nx = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr       = 1'b0;
    wr_res   = '0;
    wr_c     = 1'b0;
    wr_v     = 1'b0;
    done_nx  = 1'b0;
    ld_shift = 1'b0;
    ld_mul   = 1'b0;
    step     = 1'b0;
    case (state)
      S_IDLE: begin
        if (in_start) begin
          case (in_control)
            OP_SHL, OP_SHR: begin
              if (k == '0) begin
                wr      = 1'b1;
                wr_res  = out_acc;
                done_nx = 1'b1;
              end else begin
                ld_shift = 1'b1;
                state_nx = S_SHIFT;
              end
            end
            OP_MUL: begin
              ld_mul   = 1'b1;
              state_nx = S_MUL;
            end
            OP_ADD, OP_SUB, OP_OR, OP_ORN, OP_AND, OP_ANDN,
            OP_NOTA, OP_NOTB, OP_LOAD: begin
              wr      = 1'b1;
              wr_res  = alu_res;
              wr_c    = alu_c;
              wr_v    = alu_v;
              done_nx = 1'b1;
            end
            default: done_nx = 1'b1;
          endcase
        end
      end
      S_SHIFT: begin
        step = 1'b1;
        if (cnt == CW'(1)) begin
          wr       = 1'b1;
          wr_res   = sh_nx;
          wr_c     = sh_out;
          done_nx  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      S_MUL: begin
        step = 1'b1;
        if (cnt == CW'(1)) begin
          wr       = 1'b1;
          wr_res   = prod_nx[WIDTH-1:0];
          wr_c     = |prod_nx[2*WIDTH-1:WIDTH];
          done_nx  = 1'b1;
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      out_acc  <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      op_q     <= '0;
      cnt      <= '0;
      sh_q     <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      prod_q   <= '0;
    end else begin
      done_q <= done_nx;
      if (wr) begin
        out_acc         <= wr_res;
        flags_q[FLAG_C] <= wr_c;
        flags_q[FLAG_V] <= wr_v;
        flags_q[FLAG_Z] <= (wr_res == '0);
        flags_q[FLAG_N] <= wr_res[WIDTH-1];
      end
      if (ld_shift) begin
        op_q <= in_control;
        sh_q <= out_acc;
        cnt  <= {1'b0, k};
      end
      if (ld_mul) begin
        op_q     <= in_control;
        mcand_q  <= {{WIDTH{1'b0}}, out_acc};
        mplier_q <= in_operand;
        prod_q   <= '0;
        cnt      <= CW'(WIDTH);
      end
      if (step) begin
        cnt <= cnt - CW'(1);
        if (state == S_SHIFT) sh_q <= sh_nx;
        if (state == S_MUL) begin
          prod_q   <= prod_nx;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
        end
      end
    end
  end

  assign out_busy     = (state != S_IDLE);
  assign out_done     = done_q;
  assign out_carry    = flags_q[FLAG_C];
  assign out_zero     = flags_q[FLAG_Z];
  assign out_negative = flags_q[FLAG_N];
  assign out_overflow = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_accumulator.sv
// Directed bench for alu_accumulator (WIDTH=8) with hand-computed results,
// flags {V,N,Z,C} and done latencies.
module tb_alu_accumulator;

  logic       in_clk = 1'b0;
  logic       in_reset;
  logic       in_start;
  logic [3:0] in_control;
  logic [7:0] in_operand;
  logic       in_carry;
  logic       out_busy, out_done;
  logic [7:0] out_acc;
  logic       out_carry, out_zero, out_negative, out_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  int lat;
  logic seen_done;

  alu_accumulator #(.WIDTH(8)) dut (
    .in_clk       (in_clk),
    .in_reset     (in_reset),
    .in_start     (in_start),
    .in_control   (in_control),
    .in_operand   (in_operand),
    .in_carry     (in_carry),
    .out_busy     (out_busy),
    .out_done     (out_done),
    .out_acc      (out_acc),
    .out_carry    (out_carry),
    .out_zero     (out_zero),
    .out_negative (out_negative),
    .out_overflow (out_overflow)
  );

  always #5 in_clk = ~in_clk;
  always @(posedge in_clk) cyc <= cyc + 1;

  function automatic logic [3:0] flags();
    return {out_overflow, out_negative, out_zero, out_carry};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a start for one cycle; returns 1 time unit after the accepting edge.
  task automatic start_op(input logic [3:0] op, input logic [7:0] b, input logic cin);
    @(negedge in_clk);
    in_start   = 1'b1;
    in_control = op;
    in_operand = b;
    in_carry   = cin;
    @(posedge in_clk);
    #1;
    in_start = 1'b0;
    t0 = cyc - 1;
  endtask

  task automatic wait_done(output int latency);
    while (!out_done && (cyc - t0) < 40) begin
      @(posedge in_clk);
      #1;
    end
    latency = out_done ? (cyc - t0) : -1;
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [7:0] b,
                       input logic cin, input logic [7:0] exp_acc,
                       input logic [3:0] exp_flags, input int exp_lat);
    int l;
    start_op(op, b, cin);
    wait_done(l);
    chk({tag, "_lat"}, l, exp_lat);
    chk({tag, "_acc"}, out_acc, exp_acc);
    chk({tag, "_flags"}, flags(), exp_flags);
    chk({tag, "_busy"}, out_busy, 1'b0);
  endtask

  initial begin
    in_reset = 1'b1; in_start = 1'b0; in_control = '0; in_operand = '0; in_carry = 1'b0;
    repeat (2) @(posedge in_clk);
    #1;
    chk("rst_acc", out_acc, 8'h00);
    chk("rst_flags", flags(), 4'h0);
    chk("rst_busy_done", {out_busy, out_done}, 2'b00);
    @(negedge in_clk);
    in_reset = 1'b0;

    // Reset in the middle of a multiply
    do_op("ld0f", 4'b1000, 8'h0F, 1'b0, 8'h0F, 4'b0000, 1);
    start_op(4'b1011, 8'h0F, 1'b0);
    chk("mul_busy", out_busy, 1'b1);
    repeat (2) @(posedge in_clk);
    #3 in_reset = 1'b1;
    #1;
    chk("mrst_acc", out_acc, 8'h00);
    chk("mrst_flags", flags(), 4'h0);
    chk("mrst_busy_done", {out_busy, out_done}, 2'b00);
    @(negedge in_clk);
    in_reset = 1'b0;
    seen_done = 1'b0;
    repeat (12) begin
      @(posedge in_clk);
      #1;
      seen_done = seen_done | out_done;
    end
    chk("mrst_no_done", seen_done, 1'b0);
    do_op("add_after_rst", 4'b0000, 8'h05, 1'b1, 8'h06, 4'b0000, 1);

    // ADD / SUB flags
    do_op("ld7f", 4'b1000, 8'h7F, 1'b0, 8'h7F, 4'b0000, 1);
    do_op("add_ovf", 4'b0000, 8'h01, 1'b0, 8'h80, 4'b1100, 1);
    do_op("ldff", 4'b1000, 8'hFF, 1'b0, 8'hFF, 4'b0100, 1);
    do_op("add_cin", 4'b0000, 8'h01, 1'b1, 8'h01, 4'b0001, 1);
    do_op("ld05", 4'b1000, 8'h05, 1'b0, 8'h05, 4'b0000, 1);
    do_op("sub_eq", 4'b0001, 8'h05, 1'b0, 8'h00, 4'b0011, 1);
    do_op("ld05b", 4'b1000, 8'h05, 1'b0, 8'h05, 4'b0000, 1);
    do_op("sub_borrow", 4'b0001, 8'h06, 1'b0, 8'hFF, 4'b0100, 1);

    // Logic ops clear carry/overflow
    do_op("ldf0", 4'b1000, 8'hF0, 1'b0, 8'hF0, 4'b0100, 1);
    do_op("or", 4'b0010, 8'h0F, 1'b0, 8'hFF, 4'b0100, 1);
    do_op("andn", 4'b0101, 8'h0F, 1'b0, 8'hF0, 4'b0100, 1);
    do_op("nota", 4'b0110, 8'h00, 1'b0, 8'h0F, 4'b0000, 1);
    do_op("orn", 4'b0011, 8'hFF, 1'b0, 8'h0F, 4'b0000, 1);
    do_op("and", 4'b0100, 8'h00, 1'b0, 8'h00, 4'b0010, 1);
    do_op("notb", 4'b0111, 8'h5A, 1'b0, 8'hA5, 4'b0100, 1);

    // SHL by 3 with an ignored start while busy
    do_op("ld81", 4'b1000, 8'h81, 1'b0, 8'h81, 4'b0100, 1);
    start_op(4'b1001, 8'h03, 1'b0);
    chk("shl_busy", out_busy, 1'b1);
    chk("shl_acc_hold", out_acc, 8'h81);
    @(negedge in_clk);
    in_start = 1'b1; in_control = 4'b1000; in_operand = 8'h55;
    @(negedge in_clk);
    in_start = 1'b0;
    wait_done(lat);
    chk("shl_lat", lat, 4);
    chk("shl_acc", out_acc, 8'h08);
    chk("shl_flags", flags(), 4'b0000);
    @(posedge in_clk);
    #1;
    chk("shl_no_queue", {out_done, out_busy, out_acc}, {2'b00, 8'h08});

    do_op("shr0", 4'b1010, 8'h00, 1'b0, 8'h08, 4'b0000, 1);
    do_op("ld81b", 4'b1000, 8'h81, 1'b0, 8'h81, 4'b0100, 1);
    do_op("shr1", 4'b1010, 8'h01, 1'b0, 8'h40, 4'b0001, 2);

    // Multiply
    do_op("ld10", 4'b1000, 8'h10, 1'b0, 8'h10, 4'b0000, 1);
    do_op("mul_hi", 4'b1011, 8'h20, 1'b0, 8'h00, 4'b0011, 9);
    do_op("ld0c", 4'b1000, 8'h0C, 1'b0, 8'h0C, 4'b0000, 1);
    do_op("mul_lo", 4'b1011, 8'h0B, 1'b0, 8'h84, 4'b0100, 9);

    // Reserved opcode: done pulses, nothing changes
    do_op("rsvd", 4'b1101, 8'hFF, 1'b1, 8'h84, 4'b0100, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_accumulator.md
# alu_accumulator

- Parametrised, registered successor to the single-bit ALU slice: a WIDTH-bit ALU fused with the accumulator register and a status-flag register.
- Adds multi-cycle shift and shift-add multiply operations, driven by a start/busy/done handshake.
- Sits between the processor's control FSM and the data bus. The control FSM issues one operation per handshake; `out_acc` feeds the store and output paths.

## Interface
- `WIDTH`, default 8: datapath width. Power of two, ≥4.
- `in_clk`, in, 1: sole clock. All state updates on the rising edge.
- `in_reset`, in, 1: asynchronous, active-high reset.
- `in_start`, in, 1: request an operation. Sampled only while `out_busy`=0.
- `in_control`, in, 4: opcode. Sampled with `in_start`.
- `in_operand`, in, WIDTH: B operand. Sampled with `in_start`.
- `in_carry`, in, 1: carry-in for ADD. Sampled with `in_start`.
- `out_busy`, out, 1: a multi-cycle operation is in progress.
- `out_done`, out, 1: one-cycle pulse when a result is written.
- `out_acc`, out, WIDTH: accumulator (A operand and destination).
- `out_carry`, `out_zero`, `out_negative`, `out_overflow`, out, 1 each: status flags.

## Operation
- Reset value of every output is 0: acc, all four flags, busy, done. State returns to IDLE. Reset asserted mid-operation aborts it with no done pulse.
- Opcodes (A = acc, B = operand):
  - 0000 ADD: A+B+cin.
  - 0001 SUB: A+~B+1.
  - 0010 OR: A|B.
  - 0011 ORN: A|~B.
  - 0100 AND: A&B.
  - 0101 ANDN: A&~B.
  - 0110 NOTA: ~A.
  - 0111 NOTB: ~B.
  - 1000 LOAD: B.
  - 1001 SHL: A shifted left by k = B[log2(WIDTH)-1:0], logical.
  - 1010 SHR: A shifted right by k, logical.
  - 1011 MUL: low WIDTH bits of A×B, unsigned.
  - 1100–1111: reserved. Single-cycle no-op: acc and flags unchanged, done still pulses.
- Flags are written only when done is asserted:
  - `out_zero` = (result==0). `out_negative` = result[WIDTH-1]. Both updated by every non-reserved opcode.
  - ADD/SUB: `out_carry` = carry-out of the WIDTH+1-bit sum; for SUB, 1 means no borrow. `out_overflow` = signed overflow (operand sign bits equal, result sign differs).
  - Logic ops and LOAD: carry and overflow cleared.
  - SHL/SHR: carry = last bit shifted out (0 if k=0). Overflow cleared.
  - MUL: carry = (high half of product ≠ 0). Overflow cleared.
- State machine:
  - IDLE: on `in_start`, a single-cycle opcode (including SHL/SHR with k=0) writes acc and flags and pulses done, staying in IDLE. SHL/SHR with k≥1 capture A, k and the opcode, then go to SHIFT. MUL captures multiplicand A and multiplier B, clears the 2·WIDTH-bit product, then goes to MUL.
  - SHIFT: shift one bit per cycle and decrement the counter. On the final step, write acc and flags, pulse done, go to IDLE.
  - MUL: one shift-add step per cycle for WIDTH cycles. On the final step, write acc and flags, pulse done, go to IDLE.
- Operand and opcode are held internally. `in_*` changes while busy have no effect. `in_start` while busy is ignored, not queued.
- `out_acc` keeps its pre-operation value until the final step. Intermediate values are never visible.

## Timing
- Start is accepted at edge E0.
- Single-cycle ops: result, flags and done are visible after E0. Back-to-back starts on consecutive cycles are legal.
- SHL/SHR with k≥1: busy is high after E0 through E(k-1). Result and done are visible after Ek, and busy falls at Ek. Latency is k+1.
- MUL: same pattern with k = WIDTH. Latency is WIDTH+1.
- A new start is legal in the cycle where done is high, because busy is already 0.
- The reset edge has priority over any clock edge.

## Structure
- Package `alu_acc_pkg`:
  - opcode localparams (OP_ADD … OP_MUL)
  - state enum (S_IDLE, S_SHIFT, S_MUL)
  - flag-index constants
- Sub-module `alu_word`: combinational WIDTH-bit ALU for opcodes 0000–1000. Produces result, carry-out and overflow, replacing the chained-slice approach. The top level owns the FSM, the counter (width log2(WIDTH)+1), the product register and the flag register.

## Test plan
- Reset mid-MUL (WIDTH=8, acc=0x0F, B=0x0F, reset asserted 3 cycles after start) → all outputs 0 immediately, no done pulse. The next ADD works normally.
- LOAD 0x7F, then ADD B=0x01 cin=0 → acc=0x80, overflow=1, negative=1, carry=0, zero=0. Done 1 cycle after each start.
- LOAD 0x05, then SUB B=0x05 → acc=0x00, zero=1, carry=1. SUB B=0x06 from 0x05 → acc=0xFF, carry=0.
- LOAD 0x81, then SHL B=0x03 → busy for 3 cycles, done at latency 4, acc=0x08, carry=0. SHR B=0x00 → single cycle, acc unchanged.
- LOAD 0x10, then MUL B=0x20 → done at latency 9, acc=0x00, carry=1, zero=1. MUL 0x0C×0x0B → acc=0x84, carry=0.
- `in_start` pulsed while busy, and reserved opcode 1101 issued → the extra start is ignored. The reserved op pulses done with acc and flags unchanged.
